// File: rtl/rv_core_pkg.sv
// Shared core definitions for the integer register file and its neighbours.
//   XLEN       : default data width of an architectural register
//   NREGS      : default number of architectural registers (power of 2)
//   AW         : register address width derived from NREGS
//   reg_addr_t : register index type
//   word_t     : register data type
//   REG_ZERO   : index of the hardwired-zero register
package rv_core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_wr_arb.sv
// Priority select over the write lanes for a single register address.
//   addr_i    : register address being looked up
//   wr_en_i   : per-lane write enables
//   wr_addr_i : per-lane write addresses
//   wr_data_i : per-lane write data
//   hit_o     : some enabled lane writes addr_i this cycle (never for reg 0)
//   data_o    : data of the highest-index lane that hits, 0 when no hit
module reg_file_wr_arb import rv_core_pkg::*; #(
  parameter int XLEN = rv_core_pkg::XLEN,
  parameter int NWR  = 1,
  parameter int AW   = rv_core_pkg::AW
) (
  input  logic [AW-1:0]            addr_i,
  input  logic [NWR-1:0]           wr_en_i,
  input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
  output logic                     hit_o,
  output logic [XLEN-1:0]          data_o
);

  // Ascending scan so a later (higher-index) lane overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (addr_i != '0) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w] == addr_i)) begin
          hit_o  = 1'b1;
          data_o = wr_data_i[w];
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass and a busy scoreboard.
//   clk, rst_n : core clock (rising edge), asynchronous active-low reset
//   rd_addr    : NRD read addresses; rd_data / rd_busy are combinational per port
//   wr_en, wr_addr, wr_data : NWR writeback lanes, highest lane wins on conflict
//   rsv_en, rsv_addr        : mark a destination register busy at issue
//   busy_vec   : full scoreboard state
module reg_file_mp import rv_core_pkg::*; #(
  parameter int  XLEN  = rv_core_pkg::XLEN,
  parameter int  NREGS = rv_core_pkg::NREGS,
  parameter int  NRD   = 2,
  parameter int  NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic [NREGS-1:0]         busy_vec
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_sel [NREGS];

  // Write decode: one arbiter per register; reg 0 never hits, so it stays 0.
  for (genvar r = 0; r < NREGS; r++) begin : g_wr_dec
    reg_file_wr_arb #(.XLEN(XLEN), .NWR(NWR), .AW(AW)) u_wr_dec (
      .addr_i    (AW'(r)),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .hit_o     (wr_hit[r]),
      .data_o    (wr_sel[r])
    );
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      mem_d[r] = wr_hit[r] ? wr_sel[r] : mem_q[r];
    end
  end

  // A reservation in the same cycle as a release wins: the new producer owns the register.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports: a same-cycle write is forwarded and also hides the busy bit it releases.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic            rd_hit;
    logic [XLEN-1:0] rd_byp;

    reg_file_wr_arb #(.XLEN(XLEN), .NWR(NWR), .AW(AW)) u_rd_byp (
      .addr_i    (rd_addr[i]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .hit_o     (rd_hit),
      .data_o    (rd_byp)
    );

    // Outputs are forced to 0 while reset is held, even if a write lane is active.
    always_comb begin
      rd_data[i] = '0;
      rd_busy[i] = 1'b0;
      if (rst_n && (rd_addr[i] != '0)) begin
        rd_data[i] = rd_hit ? rd_byp : mem_q[rd_addr[i]];
        rd_busy[i] = busy_q[rd_addr[i]] & ~rd_hit;
      end
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
  import rv_core_pkg::*;

  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int NR  = 32;

  logic                 clk;
  logic                 rst_n;
  logic [NRD-1:0][4:0]  rd_addr;
  logic [NRD-1:0][31:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR-1:0][4:0]  wr_addr;
  logic [NWR-1:0][31:0] wr_data;
  logic                 rsv_en;
  logic [4:0]           rsv_addr;
  logic [NR-1:0]        busy_vec;

  int checks = 0;
  int errors = 0;

  reg_file_mp #(.XLEN(32), .NREGS(NR), .NRD(NRD), .NWR(NWR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural contents and busy flags as plain arrays.
  word_t mem_m [NR];
  bit    busy_m [NR];

  function automatic bit lane_writes(input int r, output word_t d);
    bit hit = 0;
    d = '0;
    if (r == 0) return 0;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && int'(wr_addr[w]) == r) begin
        hit = 1;
        d = wr_data[w];
      end
    return hit;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    word_t d;
    bit    wh [NR];
    word_t wd [NR];
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) begin
        mem_m[r] = '0;
        busy_m[r] = 0;
      end
    end else begin
      for (int r = 0; r < NR; r++) begin
        wh[r] = lane_writes(r, d);
        wd[r] = d;
      end
      for (int r = 1; r < NR; r++) begin
        if (wh[r]) begin
          mem_m[r] = wd[r];
          busy_m[r] = 0;
        end
        if (rsv_en && int'(rsv_addr) == r) busy_m[r] = 1;
      end
    end
  end

  always @(negedge clk) begin
    word_t d;
    bit    hit;
    logic [31:0] exp_data;
    logic        exp_busy;
    logic [NR-1:0] exp_vec;
    for (int i = 0; i < NRD; i++) begin
      hit = lane_writes(int'(rd_addr[i]), d);
      if (!rst_n || rd_addr[i] == 0) begin
        exp_data = '0;
        exp_busy = 1'b0;
      end else begin
        exp_data = hit ? d : mem_m[rd_addr[i]];
        exp_busy = busy_m[rd_addr[i]] && !hit;
      end
      chk($sformatf("model_rd_data[%0d]", i), rd_data[i], exp_data);
      chk($sformatf("model_rd_busy[%0d]", i), {31'b0, rd_busy[i]}, {31'b0, exp_busy});
    end
    for (int r = 0; r < NR; r++) exp_vec[r] = busy_m[r];
    chk("model_busy_vec", busy_vec, exp_vec);
  end

  task automatic idle();
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    rsv_en = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    idle();
    // Write attempted during reset must be neither visible nor stored.
    wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h55; rd_addr[0] = 5'd4;
    #12;
    chk("reset_rd_data_gated", rd_data[0], 32'h0);
    chk("reset_busy_vec", busy_vec, 32'h0);
    idle();
    #6 rst_n = 1'b1;
    step();
    chk("post_reset_x4", rd_data[0], 32'h0);

    // 1: preload x5 (with reservation), then async reset mid-cycle.
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd5; rd_addr[0] = 5'd5;
    step();
    idle();
    #1;
    chk("preload_x5", rd_data[0], 32'hDEADBEEF);
    chk("preload_busy5", {31'b0, busy_vec[5]}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_x5", rd_data[0], 32'h0);
    chk("async_rst_busy_vec", busy_vec, 32'h0);
    #3 rst_n = 1'b1;
    step();
    chk("after_rst_x5", rd_data[0], 32'h0);

    // 2: writes and reservations of x0 are dropped.
    wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr[0] = 5'd0;
    #1;
    chk("x0_rd_data", rd_data[0], 32'h0);
    chk("x0_rd_busy", {31'b0, rd_busy[0]}, 32'h0);
    step();
    idle();
    #1;
    chk("x0_busy_vec", {31'b0, busy_vec[0]}, 32'h0);

    // 3: bypass then storage.
    step();
    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h12345678; rd_addr[1] = 5'd7;
    #1;
    chk("bypass_x7", rd_data[1], 32'h12345678);
    step();
    idle();
    #1;
    chk("stored_x7", rd_data[1], 32'h12345678);

    // 4: two lanes to the same register, lane 1 wins.
    wr_en = 2'b11; wr_addr[0] = 5'd3; wr_data[0] = 32'h1;
    wr_addr[1] = 5'd3; wr_data[1] = 32'h2; rd_addr[2] = 5'd3;
    #1;
    chk("lane_conflict_bypass", rd_data[2], 32'h2);
    step();
    idle();
    #1;
    chk("lane_conflict_stored", rd_data[2], 32'h2);

    // 5: reserve x9, release by write three cycles later.
    rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr[3] = 5'd9;
    #1;
    chk("rsv_not_yet_visible", {31'b0, rd_busy[3]}, 32'h0);
    step();
    idle();
    #1;
    chk("rsv_visible_n1", {31'b0, rd_busy[3]}, 32'h1);
    step();
    step();
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'hA5A5;
    #1;
    chk("release_same_cycle", {31'b0, rd_busy[3]}, 32'h0);
    chk("release_state_pending", {31'b0, busy_vec[9]}, 32'h1);
    step();
    idle();
    #1;
    chk("release_busy_vec9", {31'b0, busy_vec[9]}, 32'h0);

    // 6: reserve and write x9 in the same cycle; reservation survives.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h0BADF00D;
    #1;
    chk("rsv_wr_same_bypass", rd_data[3], 32'h0BADF00D);
    step();
    idle();
    #1;
    chk("rsv_wr_busy_vec9", {31'b0, busy_vec[9]}, 32'h1);
    chk("rsv_wr_data", rd_data[3], 32'h0BADF00D);

    // Random traffic over a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      step();
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]   = ($urandom_range(0, 2) != 0);
        wr_addr[w] = 5'($urandom_range(0, 11));
        wr_data[w] = $urandom;
      end
      rsv_en   = $urandom_range(0, 1) == 1;
      rsv_addr = 5'($urandom_range(0, 11));
      for (int i = 0; i < NRD; i++) rd_addr[i] = 5'($urandom_range(0, 11));
    end
    step();
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
